// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex display driver with frame-synchronous shadow latching.
// Optional macro SEG7_DP_EN adds per-digit decimal-point control from ctrl[7:4].
module seg7_scan #(
   parameter int PRESCALE = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_lo,
   input  logic [7:0] data_hi,
   input  logic [7:0] ctrl,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_int
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pcnt;
   logic [1:0]    idx;
   logic [7:0]    sh_lo;
   logic [7:0]    sh_hi;
   logic [3:0]    sh_en;
   logic          tick;
   logic          boundary;
   logic [3:0]    nib;
   logic          lit;
   logic [6:0]    seg_dec;

`ifdef SEG7_DP_EN
   logic [3:0]    sh_dp;
`else
   logic          unused_ctrl_dp;
   assign unused_ctrl_dp = &{1'b0, ctrl[7:4]};
`endif

   assign tick     = (pcnt == PW'(PRESCALE - 1));
   assign boundary = tick && (idx == 2'd3);

   always_comb begin
      nib = 4'h0;
      case (idx)
         2'd0:    nib = sh_lo[3:0];
         2'd1:    nib = sh_lo[7:4];
         2'd2:    nib = sh_hi[3:0];
         default: nib = sh_hi[7:4];
      endcase
      lit = sh_en[idx];
   end

   // Segment patterns are {g,f,e,d,c,b,a}, active-low.
   always_comb begin
      seg_dec = 7'h7F;
      case (nib)
         4'h0: seg_dec = 7'h40;
         4'h1: seg_dec = 7'h79;
         4'h2: seg_dec = 7'h24;
         4'h3: seg_dec = 7'h30;
         4'h4: seg_dec = 7'h19;
         4'h5: seg_dec = 7'h12;
         4'h6: seg_dec = 7'h02;
         4'h7: seg_dec = 7'h78;
         4'h8: seg_dec = 7'h00;
         4'h9: seg_dec = 7'h10;
         4'hA: seg_dec = 7'h08;
         4'hB: seg_dec = 7'h03;
         4'hC: seg_dec = 7'h46;
         4'hD: seg_dec = 7'h21;
         4'hE: seg_dec = 7'h06;
         default: seg_dec = 7'h0E;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt      <= '0;
         idx       <= 2'd0;
         sh_lo     <= 8'h00;
         sh_hi     <= 8'h00;
         sh_en     <= 4'h0;
`ifdef SEG7_DP_EN
         sh_dp     <= 4'h0;
`endif
         an        <= 4'b1111;
         seg       <= 7'h7F;
         dp        <= 1'b1;
         frame_int <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick)
            idx <= idx + 2'd1;
         frame_int <= boundary;
         // Shadow copies change only here so a frame never shows mixed data.
         if (boundary) begin
            sh_lo <= data_lo;
            sh_hi <= data_hi;
            sh_en <= ctrl[3:0];
`ifdef SEG7_DP_EN
            sh_dp <= ctrl[7:4];
`endif
         end
         if (lit) begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_dec;
`ifdef SEG7_DP_EN
            dp  <= ~sh_dp[idx];
`else
            dp  <= 1'b1;
`endif
         end else begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a cycle-level reference model pushes the
// expected {an,seg,dp,frame_int} each cycle, popped and compared after the edge.
module tb_seg7_scan;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data_lo = 8'h00;
   logic [7:0] data_hi = 8'h00;
   logic [7:0] ctrl = 8'h00;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_int;

   int n_checks = 0;
   int n_errors = 0;

   logic [12:0] sb[$];
   logic [6:0]  dec_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int         mcnt = 0;
   logic [7:0] m_lo = 8'h00;
   logic [7:0] m_hi = 8'h00;
   logic [7:0] m_ctrl = 8'h00;
   int         n_frames = 0;

   seg7_scan #(.PRESCALE(P)) dut (
      .clk(clk), .reset(reset), .data_lo(data_lo), .data_hi(data_hi), .ctrl(ctrl),
      .an(an), .seg(seg), .dp(dp), .frame_int(frame_int)
   );

   always #30 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: model predicts the post-edge outputs, DUT is sampled 1 ns after the edge.
   task automatic cyc(input string tag, input logic r);
      logic [12:0] e;
      logic [3:0]  a_e;
      logic [3:0]  nb;
      logic        dp_e;
      logic        bnd;
      int          i_;
      int          ph;
      reset = r;
      if (r) begin
         e = {4'b1111, 7'h7F, 1'b1, 1'b0};
         mcnt = 0; m_lo = 8'h00; m_hi = 8'h00; m_ctrl = 8'h00;
      end else begin
         i_  = (mcnt / P) % 4;
         ph  = mcnt % P;
         bnd = (ph == P - 1) && (i_ == 3);
         nb  = (i_ < 2) ? m_lo[4*(i_%2) +: 4] : m_hi[4*(i_%2) +: 4];
         if (m_ctrl[i_]) begin
            a_e = 4'b1111;
            a_e[i_] = 1'b0;
`ifdef SEG7_DP_EN
            dp_e = ~m_ctrl[4+i_];
`else
            dp_e = 1'b1;
`endif
            e = {a_e, dec_tab[nb], dp_e, bnd};
         end else begin
            e = {4'b1111, 7'h7F, 1'b1, bnd};
         end
         if (bnd) begin
            m_lo = data_lo; m_hi = data_hi; m_ctrl = data_ctrl_mask(ctrl);
            n_frames++;
         end
         mcnt = (mcnt + 1) % (4 * P);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
      else check(tag, {19'd0, an, seg, dp, frame_int}, {19'd0, sb.pop_front()});
   endtask

   function automatic logic [7:0] data_ctrl_mask(input logic [7:0] c);
`ifdef SEG7_DP_EN
      return c;
`else
      return {4'h0, c[3:0]};
`endif
   endfunction

   task automatic run(input string tag, input int n);
      for (int k = 0; k < n; k++) cyc(tag, 1'b0);
   endtask

   initial begin
      // 1/2: reset, blank first frame, then 1-2-3-4 on all digits
      data_lo = 8'h21; data_hi = 8'h43; ctrl = 8'h0F;
      for (int k = 0; k < 3; k++) cyc("reset", 1'b1);
      run("blank_frame", 16);
      run("digits_1234", 2 * 4 * P);
      // 3: digits 1 and 3 blanked
      ctrl = 8'h05;
      run("ctrl_05", 2 * 4 * P);
      // 4: mid-frame data change, visible only from next frame
      ctrl = 8'h0F;
      run("restore", 4 * P);
      run("pre_change", 6);
      data_lo = 8'hFE;
      run("mid_change", 4 * P + 16);
      // 5: reset for one cycle while idx==2
      while (((mcnt / P) % 4) != 2) cyc("seek_idx2", 1'b0);
      cyc("mid_reset", 1'b1);
      run("post_reset", 2 * 4 * P + 2);
      // 6: decimal point behaviour
      ctrl = 8'hF1; data_lo = 8'h30;
      run("dp_f1", 3 * 4 * P);
      // Boundary-edge input changes and random traffic
      for (int k = 0; k < 6 * 4 * P; k++) begin
         data_lo = 8'($urandom); data_hi = 8'($urandom); ctrl = 8'($urandom);
         cyc("random", 1'b0);
      end
      check("frames_seen", n_frames, n_frames > 0 ? n_frames : 1);
      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
